puf_eval_ctrl: RTL and testbench
================================

Name: puf_eval_ctrl

Overview:
- Sequencer for the ring-oscillator PUF datapath: oscillator bank, two oscillator-select muxes, two edge counters.
- On `start`, walks NBITS oscillator pairs derived from a challenge seed. For each pair it:
  - clears the counters,
  - enables the oscillators for a fixed window,
  - waits for the counters to settle,
  - compares the two counts and shifts one response bit.
- Sits between the host pins and the oscillator/counter datapath; replaces the free-running compare path.

Parameters:
- NBITS, 4, response bits produced per evaluation (1..8).
- SEL_W, 3, oscillator select width; bank size is 2^SEL_W.
- CNT_W, 8, counter width of `count_a` / `count_b`.
- WINDOW, 16, clk cycles with `osc_en` high per measurement (>=1).
- SETTLE, 4, clk cycles with `osc_en` low before sampling counts (>=1).

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-high reset (asserted when 1, despite the name).
- start, input, 1, begin evaluation; sampled only in IDLE.
- challenge, input, SEL_W, pair seed; captured on accepted start.
- count_a, input, CNT_W, counter value for oscillator `sel_a`.
- count_b, input, CNT_W, counter value for oscillator `sel_b`.
- osc_en, output, 1, oscillator/counter enable.
- cnt_clr, output, 1, counter clear (active high).
- sel_a, output, SEL_W, oscillator select A.
- sel_b, output, SEL_W, oscillator select B.
- busy, output, 1, high from the accepted start until done.
- done, output, 1, one-cycle pulse when the response is complete.
- response, output, NBITS, response word; holds until the next accepted start.
- tie_cnt, output, 4, count of equal-count comparisons in the last evaluation; saturates at 15.

Behaviour:
- **Reset** (`rst_n`=1, asynchronous): state=IDLE, all outputs 0, internal bit index k=0, window/settle counters 0.
- **IDLE**:
  - `start`=1 at an edge → capture `challenge` into seed.
  - Clear `response` and `tie_cnt`; k=0; `busy`=1; go to CLEAR.
  - `start` in any other state is ignored.
- **Pair selection**: `sel_a` = seed + 2k and `sel_b` = seed + 2k + 1, both truncated to SEL_W bits (wrap-around). Stable from CLEAR through SAMPLE of pair k.
- **CLEAR**: `cnt_clr`=1 for exactly 2 cycles, `osc_en`=0, then RUN.
- **RUN**: `osc_en`=1 for exactly WINDOW cycles, then SETTLE.
- **SETTLE**: `osc_en`=0 for exactly SETTLE cycles, then SAMPLE.
- **SAMPLE** (1 cycle):
  - `response[k]` = (`count_a` > `count_b`), unsigned CNT_W compare.
  - If equal: bit = 0 and `tie_cnt` increments (saturating).
  - If k = NBITS-1: go to DONE. Otherwise k++ and go to CLEAR.
- **Cycle budget**: 3 + WINDOW + SETTLE cycles per bit (23 at defaults).
- **DONE** (1 cycle): `done`=1, `busy`=0 in the same cycle, return to IDLE.
  - A `start` on the cycle after DONE is accepted.
- **Held outputs**: `response` and `tie_cnt` hold after DONE. `sel_a`/`sel_b` hold their last values in IDLE.
- **Reset mid-evaluation**: immediate return to IDLE, partial response discarded (0), `osc_en`/`cnt_clr` drop asynchronously.
- **Clock-domain note**: the counters run in the oscillator domain. `count_a`/`count_b` are only sampled after SETTLE cycles with `osc_en` low, so no synchronizer is required.

Optional Feature:
- Macro: PUF_MAJORITY_EN.
- Defined:
  - Each pair is measured 3 times (CLEAR→RUN→SETTLE→SAMPLE repeated, same `sel_a`/`sel_b`).
  - `response[k]` = majority of the 3 comparisons.
  - `tie_cnt` counts each equal comparison.
  - Per-bit cost is 3*(3+WINDOW+SETTLE) cycles.
- Undefined: single measurement per bit as above; no vote logic or repeat counter is synthesized.

Test Plan:
1. **Single bit, A faster**: reset, `challenge`=3'd2, `start` pulse, model returns `count_a`=100, `count_b`=90 for every pair. Expect `sel_a`/`sel_b` = 2/3, 4/5, 6/7, 0/1 (wrap); `response`=4'b1111; `done` exactly 92 cycles after `start` accepted; `tie_cnt`=0.
2. **Mixed and ties**: pairs return (a,b) = (50,60), (70,70), (80,10), (0,255). Expect `response`=4'b0100, `tie_cnt`=1.
3. **Waveform timing**: check `cnt_clr` high exactly 2 cycles, then `osc_en` high exactly 16 cycles, then low 4 cycles before each sample. `osc_en` and `cnt_clr` never high together.
4. **Start while busy**: pulse `start` with `challenge`=7 mid-RUN of bit 1. Expect it ignored: seed unchanged, `done` still at cycle 92. A `start` the cycle after `done` is accepted.
5. **Reset mid-operation**: assert `rst_n` during SETTLE of bit 2. Expect `osc_en`, `busy`, `response`, `tie_cnt` = 0 immediately; IDLE after release; the next `start` runs a full evaluation.
6. **PUF_MAJORITY_EN defined**: pair 0 returns a>b, a<b, a>b across its 3 runs. Expect `response[0]`=1 and `done` at 276 cycles.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// Sequencer for the ring-oscillator PUF datapath: selects oscillator pairs, runs timed clear/run/settle windows and compares counts.
// Latency: (3 + WINDOW + SETTLE) clk per response bit (x3 with PUF_MAJORITY_EN), plus one DONE cycle; done pulses NBITS*budget cycles after start.
// Backpressure: none; start is only sampled in IDLE and ignored while busy. Optional macro: PUF_MAJORITY_EN (3 measurements per bit, majority vote).
//
// Ports:
//   clk, rst_n (asynchronous, active HIGH despite the name)
//   start, challenge       : host request and pair seed
//   count_a, count_b       : edge counter values for sel_a / sel_b
//   osc_en, cnt_clr        : oscillator/counter enable and counter clear
//   sel_a, sel_b           : oscillator selects for the current pair
//   busy, done, response, tie_cnt : status and result
module puf_eval_ctrl #(
    parameter int NBITS  = 4,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] challenge,
    input  logic [CNT_W-1:0] count_a,
    input  logic [CNT_W-1:0] count_b,
    output logic             osc_en,
    output logic             cnt_clr,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] response,
    output logic [3:0]       tie_cnt
);

    localparam int KW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_seed;
    logic [KW-1:0]      r_k;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_osc_en;
    logic               r_cnt_clr;
    logic [SEL_W-1:0]   r_sel_a;
    logic [SEL_W-1:0]   r_sel_b;
    logic               r_busy;
    logic               r_done;
    logic [NBITS-1:0]   r_response;
    logic [3:0]         r_tie;

    logic               w_gt;
    logic               w_eq;
    logic               w_bit;
    logic               w_meas_done;
    logic [3:0]         w_tie_nxt;
    logic [SEL_W-1:0]   w_next_a;
    logic [SEL_W-1:0]   w_next_b;

    assign w_gt      = (count_a > count_b);
    assign w_eq      = (count_a == count_b);
    assign w_tie_nxt = (r_tie == 4'hF) ? r_tie : r_tie + 4'd1;

    // Next pair base = seed + 2*(k+1), wrapping in the SEL_W-bit select space.
    assign w_next_a = SEL_W'(32'(r_seed) + 32'd2 * (32'(r_k) + 32'd1));
    assign w_next_b = w_next_a + SEL_W'(1);

`ifdef PUF_MAJORITY_EN
    // r_rep counts completed measurements of the current pair; r_votes counts a>b outcomes.
    logic [1:0] r_rep;
    logic [1:0] r_votes;
    logic [1:0] w_vote_total;

    assign w_vote_total = r_votes + {1'b0, w_gt};
    assign w_meas_done  = (r_rep == 2'd2);
    assign w_bit        = (w_vote_total >= 2'd2);
`else
    assign w_meas_done  = 1'b1;
    assign w_bit        = w_gt;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_seed     <= '0;
            r_k        <= '0;
            r_tmr      <= '0;
            r_osc_en   <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_response <= '0;
            r_tie      <= '0;
`ifdef PUF_MAJORITY_EN
            r_rep      <= '0;
            r_votes    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_seed     <= challenge;
                        r_sel_a    <= challenge;
                        r_sel_b    <= challenge + SEL_W'(1);
                        r_k        <= '0;
                        r_tmr      <= '0;
                        r_response <= '0;
                        r_tie      <= '0;
                        r_busy     <= 1'b1;
                        r_cnt_clr  <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end

                // Counter clear is held for two cycles.
                S_CLEAR: begin
                    if (r_tmr == TMR_W'(1)) begin
                        r_tmr     <= '0;
                        r_cnt_clr <= 1'b0;
                        r_osc_en  <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end

                S_RUN: begin
                    if (r_tmr == TMR_W'(WINDOW - 1)) begin
                        r_tmr    <= '0;
                        r_osc_en <= 1'b0;
                        r_state  <= S_SETTLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end

                // Oscillators are off here, so the counters are quiescent by SAMPLE.
                S_SETTLE: begin
                    if (r_tmr == TMR_W'(SETTLE - 1)) begin
                        r_tmr   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end

                S_SAMPLE: begin
                    if (w_eq) begin
                        r_tie <= w_tie_nxt;
                    end
`ifdef PUF_MAJORITY_EN
                    r_rep   <= w_meas_done ? 2'd0 : r_rep + 2'd1;
                    r_votes <= w_meas_done ? 2'd0 : w_vote_total;
`endif
                    if (w_meas_done) begin
                        r_response[r_k] <= w_bit;
                        if (r_k == KW'(NBITS - 1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_k       <= r_k + KW'(1);
                            r_sel_a   <= w_next_a;
                            r_sel_b   <= w_next_b;
                            r_cnt_clr <= 1'b1;
                            r_state   <= S_CLEAR;
                        end
                    end else begin
                        // Repeat measurement of the same pair.
                        r_cnt_clr <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign osc_en   = r_osc_en;
    assign cnt_clr  = r_cnt_clr;
    assign sel_a    = r_sel_a;
    assign sel_b    = r_sel_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign response = r_response;
    assign tie_cnt  = r_tie;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: directed evaluations, waveform timing monitor, start-while-busy and reset-abort cases.
// Latency: expects done NBITS*REP*23 cycles after the accepted start (REP = 3 with PUF_MAJORITY_EN, else 1).
// Backpressure: n/a; a negedge monitor pops expected results on each done pulse.
module tb_puf_eval_ctrl;

`ifdef PUF_MAJORITY_EN
    localparam int REP = 3;
`else
    localparam int REP = 1;
`endif
    localparam int BIT_CYC = 23;
    localparam int LAT     = 4 * REP * BIT_CYC;

    typedef struct {
        logic [3:0] resp;
        logic [3:0] tie;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [2:0] challenge = 3'd0;
    logic [7:0] count_a;
    logic [7:0] count_b;
    logic       osc_en, cnt_clr, busy, done;
    logic [2:0] sel_a, sel_b;
    logic [3:0] response, tie_cnt;

    puf_eval_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .challenge(challenge),
        .count_a  (count_a),
        .count_b  (count_b),
        .osc_en   (osc_en),
        .cnt_clr  (cnt_clr),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .busy     (busy),
        .done     (done),
        .response (response),
        .tie_cnt  (tie_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t       exp_q[$];
    logic [5:0] sel_q[$];

    // Counter model: one table entry per measurement, indexed by cnt_clr pulses.
    logic [7:0] tab_a[0:15];
    logic [7:0] tab_b[0:15];
    int         meas = 0;
    assign count_a = tab_a[(meas == 0) ? 0 : meas - 1];
    assign count_b = tab_b[(meas == 0) ? 0 : meas - 1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor state
    logic prev_clr = 1'b0, prev_osc = 1'b0, prev_busy = 1'b0;
    int   clr_len = 0, osc_len = 0, gap = 0, t_busy = 0;
    logic gap_act = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            prev_clr  <= 1'b0;
            prev_osc  <= 1'b0;
            prev_busy <= 1'b0;
            clr_len   <= 0;
            osc_len   <= 0;
            gap       <= 0;
            gap_act   <= 1'b0;
            meas      <= 0;
        end else begin
            prev_clr  <= cnt_clr;
            prev_osc  <= osc_en;
            prev_busy <= busy;
            if (osc_en || cnt_clr)
                chk("osc_clr_overlap", int'(osc_en && cnt_clr), 0);
            // cnt_clr run length and pair selection at each clear
            if (cnt_clr) begin
                clr_len <= clr_len + 1;
                if (!prev_clr) begin
                    meas <= meas + 1;
                    if (sel_q.size() == 0) begin
                        chk("sel_unexpected_clear", 1, 0);
                    end else begin
                        logic [5:0] ep;
                        ep = sel_q.pop_front();
                        chk("sel_a", int'(sel_a), int'(ep[5:3]));
                        chk("sel_b", int'(sel_b), int'(ep[2:0]));
                    end
                end
            end else if (prev_clr) begin
                chk("cnt_clr_len", clr_len, 2);
                clr_len <= 0;
            end
            // osc_en run length; run must directly follow a clear
            if (osc_en) begin
                osc_len <= osc_len + 1;
                if (!prev_osc) chk("run_after_clear", int'(prev_clr), 1);
            end else if (prev_osc) begin
                chk("osc_en_len", osc_len, 16);
                osc_len <= 0;
                gap     <= 1;
                gap_act <= 1'b1;
            end else if (gap_act) begin
                // SETTLE low cycles plus the SAMPLE cycle before next clear/done
                if (cnt_clr || done) begin
                    chk("settle_sample_gap", gap, 5);
                    gap_act <= 1'b0;
                end else begin
                    gap <= gap + 1;
                end
            end
            if (busy && !prev_busy) t_busy <= cyc;
            if (done) begin
                meas <= 0;
                chk("busy_low_at_done", int'(busy), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("response", int'(response), int'(e.resp));
                    chk("tie_cnt", int'(tie_cnt), int'(e.tie));
                    chk("done_latency", cyc - t_busy, e.lat);
                end
            end
        end
    end

    task automatic fill(input int pair, input logic [7:0] a, input logic [7:0] b);
        for (int r = 0; r < REP; r++) begin
            tab_a[pair*REP + r] = a;
            tab_b[pair*REP + r] = b;
        end
    endtask

    // Push expected pairs and result, then issue a one-cycle start.
    task automatic do_start(input logic [2:0] ch, input logic [3:0] resp, input logic [3:0] tie, input logic push_res);
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            logic [2:0] a;
            a = ch + 3'(2 * p);
            for (int r = 0; r < REP; r++) sel_q.push_back({a, a + 3'd1});
        end
        if (push_res) begin
            e.resp = resp; e.tie = tie; e.lat = LAT;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        challenge = ch;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < LAT + 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk(name, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tab_a[i] = 8'd0;
            tab_b[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_osc_en", int'(osc_en), 0);
        chk("rst_cnt_clr", int'(cnt_clr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sels", int'({sel_a, sel_b}), 0);
        chk("rst_resp_tie", int'({response, tie_cnt}), 0);
        rst_n = 1'b0;

        // 1: all pairs a>b, wrap-around selects
        for (int p = 0; p < 4; p++) fill(p, 8'd100, 8'd90);
        do_start(3'd2, 4'b1111, 4'd0, 1'b1);
        wait_done("t1_done_timeout");

        // 2: mixed and ties
        fill(0, 8'd50, 8'd60); fill(1, 8'd70, 8'd70); fill(2, 8'd80, 8'd10); fill(3, 8'd0, 8'd255);
        do_start(3'd0, 4'b0100, 4'd1, 1'b1);
        wait_done("t2_done_timeout");
        chk("t2_resp_hold", int'(response), 4);
        repeat (4) @(posedge clk);
        #1 chk("t2_tie_hold", int'(tie_cnt), 1);

        // 4: start mid-RUN of bit 1 ignored, then back-to-back start after done
        do_start(3'd5, 4'b0100, 4'd1, 1'b1);
        repeat (REP * BIT_CYC + 7) @(posedge clk);
        #1;
        chk("t4_in_run", int'(osc_en), 1);
        challenge = 3'd7;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        wait_done("t4_done_timeout");
        for (int p = 0; p < 4; p++) fill(p, 8'd100, 8'd90);
        do_start(3'd1, 4'b1111, 4'd0, 1'b1);
        wait_done("t4b_done_timeout");

        // 5: reset during SETTLE of bit 2
        fill(0, 8'd100, 8'd90); fill(1, 8'd70, 8'd70); fill(2, 8'd10, 8'd20); fill(3, 8'd10, 8'd20);
        do_start(3'd4, 4'b0000, 4'd0, 1'b0);
        repeat (2 * REP * BIT_CYC + (REP - 1) * BIT_CYC + 19) @(posedge clk);
        #1;
        chk("t5_pre_resp", int'(response), 1);
        chk("t5_pre_tie", int'(tie_cnt), 1);
        rst_n = 1'b1;
        #1;
        chk("t5_rst_osc_en", int'(osc_en), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_resp", int'(response), 0);
        chk("t5_rst_tie", int'(tie_cnt), 0);
        sel_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t5_idle", int'({busy, osc_en, cnt_clr}), 0);
        fill(0, 8'd200, 8'd100); fill(1, 8'd5, 8'd5); fill(2, 8'd5, 8'd5); fill(3, 8'd9, 8'd8);
        do_start(3'd6, 4'b1001, 4'd2, 1'b1);
        wait_done("t5_done_timeout");

`ifdef PUF_MAJORITY_EN
        // 6: majority vote per pair
        tab_a[0] = 8'd100; tab_b[0] = 8'd90;
        tab_a[1] = 8'd10;  tab_b[1] = 8'd20;
        tab_a[2] = 8'd100; tab_b[2] = 8'd90;
        tab_a[3] = 8'd10;  tab_b[3] = 8'd20;
        tab_a[4] = 8'd100; tab_b[4] = 8'd90;
        tab_a[5] = 8'd10;  tab_b[5] = 8'd20;
        tab_a[6] = 8'd5;   tab_b[6] = 8'd5;
        tab_a[7] = 8'd5;   tab_b[7] = 8'd5;
        tab_a[8] = 8'd9;   tab_b[8] = 8'd1;
        fill(3, 8'd9, 8'd1);
        do_start(3'd3, 4'b1001, 4'd2, 1'b1);
        wait_done("t6_done_timeout");
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("all_results_seen", exp_q.size(), 0);
        chk("all_pairs_seen", sel_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
